// File: rtl/cmp_sort_pkg.sv
// Shared types and constants for the 4-element sequential bubble sorter.
package cmp_sort_pkg;

  localparam int unsigned NUM_ELEM  = 4;
  localparam int unsigned NUM_STEPS = 6;
  localparam int unsigned STEP_W    = 3;
  localparam int unsigned IDX_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Pair index j for steps 0..5 (step 0 in the LSBs): 0,1,2,0,1,0
  localparam logic [IDX_W*NUM_STEPS-1:0] PAIR_TABLE =
    {2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

  // Look up the adjacent-pair index compared at a given step.
  function automatic logic [IDX_W-1:0] pair_idx(input logic [STEP_W-1:0] step);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned s = 0; s < NUM_STEPS; s++) begin
      if (step == STEP_W'(s)) idx = PAIR_TABLE[IDX_W*s +: IDX_W];
    end
    return idx;
  endfunction

endpackage

// File: rtl/comparator.sv
// WIDTH-bit unsigned magnitude comparator.
module comparator #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  // Pure combinational compare of a against b.
  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Sequential 4-element bubble sorter: one compare-and-swap per cycle, fixed 6-step latency.
module cmp_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      descend,
  input  logic [NUM_ELEM*WIDTH-1:0] data_in,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_ELEM*WIDTH-1:0] sorted_out,
  output logic [2:0]                swap_count
);

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          elem_q [NUM_ELEM];
  logic [WIDTH-1:0]          elem_d [NUM_ELEM];
  logic [STEP_W-1:0]         step_q, step_d;
  logic                      desc_q, desc_d;
  logic [2:0]                swap_cnt_q, swap_cnt_d;
  logic [NUM_ELEM*WIDTH-1:0] sorted_q, sorted_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [IDX_W-1:0]          pair_j;
  logic [IDX_W-1:0]          pair_k;
  logic                      cmp_gt, cmp_lt, cmp_eq;
  logic                      do_swap;
  logic                      last_step;
  logic                      accept;

  // Time-shared comparator fed from the currently selected adjacent pair.
  assign pair_j = pair_idx(step_q);
  assign pair_k = IDX_W'(pair_j + IDX_W'(1));

  comparator #(.WIDTH(WIDTH)) u_cmp (
    .a  (elem_q[pair_j]),
    .b  (elem_q[pair_k]),
    .gt (cmp_gt),
    .lt (cmp_lt),
    .eq (cmp_eq)
  );

  assign do_swap   = !cmp_eq && (desc_q ? cmp_lt : cmp_gt);
  assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));
  assign accept    = start && (state_q != ST_SORT);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      desc_q     <= 1'b0;
      swap_cnt_q <= '0;
      sorted_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NUM_ELEM; i++) elem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      desc_q     <= desc_d;
      swap_cnt_q <= swap_cnt_d;
      sorted_q   <= sorted_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int i = 0; i < NUM_ELEM; i++) elem_q[i] <= elem_d[i];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SORT;
      ST_SORT: if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_SORT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    for (int i = 0; i < NUM_ELEM; i++) elem_d[i] = elem_q[i];
    step_d     = step_q;
    desc_d     = desc_q;
    swap_cnt_d = swap_cnt_q;
    sorted_d   = sorted_q;

    if (state_q == ST_SORT) begin
      if (do_swap) begin
        elem_d[pair_j] = elem_q[pair_k];
        elem_d[pair_k] = elem_q[pair_j];
        swap_cnt_d     = 3'(swap_cnt_q + 3'd1);
      end
      if (last_step) begin
        step_d = '0;
        for (int i = 0; i < NUM_ELEM; i++) sorted_d[i*WIDTH +: WIDTH] = elem_d[i];
      end else begin
        step_d = STEP_W'(step_q + STEP_W'(1));
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_ELEM; i++) elem_d[i] = data_in[i*WIDTH +: WIDTH];
      desc_d     = descend;
      swap_cnt_d = '0;
      step_d     = '0;
    end

    busy_d = (state_d == ST_SORT);
    done_d = (state_d == ST_DONE);
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sorted_out = sorted_q;
  assign swap_count = swap_cnt_q;

endmodule

// File: doc/cmp_sort_ctrl.md
CMP_SORT_CTRL -- requirements
Module: cmp_sort_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 3, bit width of one element; the element count is fixed at 4.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to sort data_in; accepted only in IDLE or DONE.
REQ-005 SHALL have port: descend  input  1  sort order, sampled with start (0 = ascending, 1 = descending).
REQ-006 SHALL have port: data_in  input  4*WIDTH  packed elements {e3,e2,e1,e0}, e0 at bits [WIDTH-1:0].
REQ-007 SHALL have port: busy  output  1  high while state is SORT.
REQ-008 SHALL have port: done  output  1  high for exactly the one cycle the FSM is in DONE.
REQ-009 SHALL have port: sorted_out  output  4*WIDTH  result, same packing as data_in; element 0 is first in the chosen order.
REQ-010 SHALL have port: swap_count  output  3  number of swaps performed in the last sort (0..6).

Function
REQ-011 SHALL implement the FSM states IDLE, SORT and DONE, all outputs registered.
REQ-012 SHALL, on an edge with start=1 in IDLE or DONE, load data_in into four element registers, latch descend, clear swap_count and the step counter, and enter SORT.
REQ-013 SHALL ignore start while in SORT, with no effect on state, data or counters.
REQ-014 SHALL, in SORT, perform exactly one compare-and-conditional-swap per cycle for 6 steps, with step 0..5 mapping to pair index j = 0,1,2,0,1,0 (bubble sort, adjacent pair e[j], e[j+1]).
REQ-015 SHALL swap the pair when descend=0 and e[j] > e[j+1], or when descend=1 and e[j] < e[j+1]; equal elements SHALL never swap.
REQ-016 SHALL increment swap_count by 1 on every swap, and swap_count SHALL never wrap because the maximum is 6.
REQ-017 SHALL, on the edge completing step 5, enter DONE and update sorted_out with the final element registers.
REQ-018 SHALL give a fixed latency: with start sampled at edge k, done is high in the cycle after edge k+6, independent of the data.
REQ-019 SHALL, from DONE, go to IDLE on the next edge unless start=1, in which case it SHALL re-enter SORT (back-to-back operation, no idle cycle).
REQ-020 SHALL hold sorted_out and swap_count stable from DONE until the edge after the next accepted start; sorted_out SHALL not change during SORT.
REQ-021 SHALL ensure data_in changes after the start edge have no effect on the sort in progress.

Reset
REQ-022 SHALL, when rst=1 at a clock edge (including mid-SORT), force state IDLE, busy=0, done=0, sorted_out=0, swap_count=0, step counter=0 and element registers=0.
REQ-023 SHALL give rst priority over start when both are high on the same edge.

Structure
REQ-024 SHALL place the FSM state enum, the step count constant (6) and the step-to-pair-index table in the shared package cmp_sort_pkg.
REQ-025 SHALL instantiate exactly one sub-module, comparator (WIDTH-bit magnitude compare with gt/lt/eq outputs), time-shared across all 6 steps, with its inputs muxed from e[j] and e[j+1].

Verification
REQ-026 SHALL verify: descend=0, data_in=12'h3DD (e0..e3 = 5,3,7,1) -> done 7 cycles after start, sorted_out=12'hF59 (1,3,5,7), swap_count=4.
REQ-027 SHALL verify: descend=0, data_in=12'h688 (0,1,2,3, already sorted) -> sorted_out=12'h688, swap_count=0; then descend=1 with the same data -> sorted_out=12'h053, swap_count=6.
REQ-028 SHALL verify: data_in=12'h924 (all 4s), either order -> sorted_out=12'h924, swap_count=0.
REQ-029 SHALL verify: start pulsed again at SORT step 3 with different data -> ignored; result matches the first data set; data_in toggled mid-sort -> no effect.
REQ-030 SHALL verify: rst asserted at SORT step 2 -> next cycle IDLE, busy=0, done=0, sorted_out=0, swap_count=0; a following start sorts correctly.
REQ-031 SHALL verify: start held high in the DONE cycle with new data -> busy high the next cycle, second done exactly 7 cycles later, with sorted_out of the first result held until that edge.
